// File: rtl/stopwatch_core.sv
// Centisecond BCD stopwatch (SS.cc) feeding the four-digit display scanner.
// Build option: define STOPWATCH_LAP_EN to add the lap/freeze button path.

module stopwatch_btn #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_done;

    assign w_diff  = r_sync2 ^ r_level;
    assign w_done  = w_diff && (r_cnt == CW'(DEB_CYCLES - 1));
    assign o_pulse = r_pulse;

    // Synchronize the raw button, accept a new level after a full stable run, pulse on press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_pulse <= w_done & r_sync2;
            if (w_done) begin
                r_level <= r_sync2;
                r_cnt   <= {CW{1'b0}};
            end else if (w_diff) begin
                r_cnt   <= r_cnt + CW'(1);
            end else begin
                r_cnt   <= {CW{1'b0}};
            end
        end
    end
endmodule

module stopwatch_core #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 100,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_clr,
    input  logic        btn_lap,
    output logic [15:0] tim,
    output logic        running,
    output logic        wrap
);
    localparam int PER = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(PER);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_pre;
    logic [15:0]   r_cnt;
    logic          r_running;
    logic          r_wrap;
    logic          w_p_start;
    logic          w_p_clr;
    logic          w_tick;
    logic [16:0]   w_inc;
    logic [15:0]   w_cnt_nxt;

    // Increment SS.cc in BCD; out-of-range digits roll over instead of sticking. Bit 16 flags 59.99 -> 00.00.
    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
        logic       carry_out;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        d3 = v[15:12];
        carry_out = 1'b0;
        if (d0 < 4'd9) begin
            d0 = d0 + 4'd1;
        end else begin
            d0 = 4'd0;
            if (d1 < 4'd9) begin
                d1 = d1 + 4'd1;
            end else begin
                d1 = 4'd0;
                if (d2 < 4'd9) begin
                    d2 = d2 + 4'd1;
                end else begin
                    d2 = 4'd0;
                    if (d3 < 4'd5) begin
                        d3 = d3 + 4'd1;
                    end else begin
                        d3 = 4'd0;
                        carry_out = 1'b1;
                    end
                end
            end
        end
        return {carry_out, d3, d2, d1, d0};
    endfunction

    stopwatch_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_start (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_start),
        .o_pulse (w_p_start)
    );

    stopwatch_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_clr (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_clr),
        .o_pulse (w_p_clr)
    );

    assign w_tick = (r_state == S_RUN) && (r_pre == PW'(PER - 1));
    assign w_inc  = bcd_inc(r_cnt);

    // Next internal count: cleared by the clear button, advanced on each prescaler tick.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_p_clr) begin
            w_cnt_nxt = 16'h0000;
        end else if (w_tick) begin
            w_cnt_nxt = w_inc[15:0];
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Start/pause/clear state machine with prescaler, count and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pre     <= {PW{1'b0}};
            r_cnt     <= 16'h0000;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
        end else if (w_p_clr) begin
            r_state   <= S_IDLE;
            r_pre     <= {PW{1'b0}};
            r_cnt     <= 16'h0000;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_wrap <= w_tick & w_inc[16];
            case (r_state)
                S_IDLE: begin
                    r_pre <= {PW{1'b0}};
                    if (w_p_start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end else begin
                        r_running <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_pre <= w_tick ? {PW{1'b0}} : (r_pre + PW'(1));
                    if (w_p_start) begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end else begin
                        r_running <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    // Prescaler holds so a resume finishes the interrupted period.
                    if (w_p_start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end else begin
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_pre     <= {PW{1'b0}};
                    r_running <= 1'b0;
                end
            endcase
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        w_p_lap;
    logic        w_freeze_nxt;
    logic        r_freeze;
    logic [15:0] r_tim;

    stopwatch_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_lap (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_lap),
        .o_pulse (w_p_lap)
    );

    // Lap toggles freeze while running; in pause it can only release.
    always_comb begin
        w_freeze_nxt = r_freeze;
        if (w_p_clr) begin
            w_freeze_nxt = 1'b0;
        end else if (w_p_lap && (r_state == S_RUN)) begin
            w_freeze_nxt = ~r_freeze;
        end else if (w_p_lap && (r_state == S_PAUSE)) begin
            w_freeze_nxt = 1'b0;
        end else begin
            w_freeze_nxt = r_freeze;
        end
    end

    // Display register tracks the live count except while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_freeze <= 1'b0;
            r_tim    <= 16'h0000;
        end else begin
            r_freeze <= w_freeze_nxt;
            if (!w_freeze_nxt) begin
                r_tim <= w_cnt_nxt;
            end else begin
                r_tim <= r_tim;
            end
        end
    end

    assign tim = r_tim;
`else
    logic w_unused_lap;
    assign w_unused_lap = btn_lap;
    assign tim          = r_cnt;
`endif

    assign running = r_running;
    assign wrap    = r_wrap;
endmodule
